shift_counter_n: RTL and testbench
==================================

Name: shift_counter_n

Overview:
Parametrised ring/Johnson shift counter and the next-generation replacement for the fixed 4-bit ring counter. It provides selectable ring (one-hot, period WIDTH) or Johnson (twisted-ring, period 2*WIDTH) sequencing, both shift directions, and count enable. It also supports parallel load, self-correction of illegal states, and wrap/illegal status pulses. It is used as a phase/sequence generator for multi-cycle datapath control.

Parameters:
WIDTH, 4, number of state bits; legal range WIDTH >= 2.
RESET_POS, WIDTH-1, index of the hot bit in the ring-mode home state; legal range 0..WIDTH-1.

Ports:
clock  input  1  single clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  advance one step per clock edge when high.
mode  input  1  0 = ring, 1 = Johnson; sampled every edge.
dir  input  1  0 = shift toward bit 0 (q[i] <= q[i+1]); 1 = shift toward MSB (q[i] <= q[i-1]).
load  input  1  parallel load strobe.
load_value  input  WIDTH  value loaded when load = 1.
q  output  WIDTH  counter state, registered.
wrap  output  1  registered one-cycle pulse: the step just taken reached the home state.
illegal  output  1  registered one-cycle pulse: the step just taken was a self-correction.

Behaviour:
- Home state: ring = one-hot with only bit RESET_POS set; Johnson = all zeros.
- Priority at each rising edge: reset > load > enable > hold.
- Reset: q <= home state for the current mode input; wrap <= 0; illegal <= 0. This applies regardless of load and enable. Reset mid-sequence abandons the sequence.
- Load: q <= load_value verbatim, with no legality check at load time; wrap <= 0; illegal <= 0.
- Hold (enable = 0, no reset, no load): q unchanged; wrap <= 0; illegal <= 0.
- Enabled step: first check the legality of the current q against the current mode.
  - Ring legal: popcount(q) == 1.
  - Johnson legal: the number of i in 0..WIDTH-2 with q[i] != q[i+1] is <= 1.
- Illegal q: q <= home state; illegal <= 1; wrap <= 0. This cycle performs no shift.
- Legal q, ring: dir = 0 gives q <= {q[0], q[W-1:1]}; dir = 1 gives q <= {q[W-2:0], q[W-1]}.
- Legal q, Johnson: dir = 0 gives q <= {~q[0], q[W-1:1]}; dir = 1 gives q <= {q[W-2:0], ~q[W-1]}.
- wrap <= 1 exactly when a legal shift produces the home state. A correction to home does not assert wrap. illegal <= 0 on legal steps.
- Periods with constant mode and dir: ring = WIDTH steps, Johnson = 2*WIDTH steps, so wrap fires once per period.
- Mode change mid-sequence: the new mode applies on the next enabled edge. If the state is illegal for the new mode, it is corrected (e.g. 0100 in Johnson). A one-hot value with the hot bit at index 0 or WIDTH-1 is legal in both modes and continues shifting.
- Dir change: takes effect on the same edge it is sampled; no correction is implied.
- Latency: every input acts on the next rising edge, and q, wrap and illegal all update together. No combinational path exists from inputs to outputs.

Test Plan:
(All with WIDTH=4, RESET_POS=3.)
1. reset with mode=0, then enable=1 and dir=0 for 4 edges -> q=0100, 0010, 0001, 1000; wrap=1 only on the 1000 step; illegal stays 0.
2. reset with mode=1, then enable=1 and dir=0 for 8 edges -> q=1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; wrap=1 only on the final 0000.
3. Mode=0, q=1000, dir=1 -> 0001, 0010, 0100, 1000 with wrap on 1000. Mode=1 from 0000 with dir=1 -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
4. load=1 with load_value=1010 and mode=0 -> q=1010 and illegal=0. Next enabled edge -> q=1000, illegal=1, wrap=0. Then normal stepping to 0100 with illegal=0.
5. Mode=1, load 0110, then enable -> q=0000, illegal=1, wrap=0. Load 0000 with mode=0, then enable -> q=1000, illegal=1.
6. enable=0 for 3 edges -> q holds and wrap=0. Reset, load and enable all high on one edge -> q=home, wrap=0, illegal=0. Mode switched 0->1 at q=0100 with enable -> q=0000, illegal=1.

Source files
------------

// File: rtl/shift_counter_n.sv
// shift_counter_n: parametrised ring / Johnson shift counter.
// Ring mode circulates a single hot bit (period WIDTH); Johnson mode
// circulates a twisted-ring pattern (period 2*WIDTH). Both directions are
// supported, plus parallel load, self-correction of states that are not
// legal for the current mode, and registered wrap / illegal pulses.
module shift_counter_n #(
    parameter int WIDTH     = 4,
    parameter int RESET_POS = WIDTH - 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             illegal
);

    // Home states: ring is one-hot at RESET_POS, Johnson is all zeros.
    logic [WIDTH-1:0] ring_home;
    logic [WIDTH-1:0] home_state;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ring_home
            assign ring_home[gi] = (gi == RESET_POS) ? 1'b1 : 1'b0;
        end
    endgenerate

    assign home_state = mode ? '0 : ring_home;

    // State registers.
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             illegal_reg;
    logic             illegal_next;

    // Adjacent-bit transitions of the current state; a legal Johnson word
    // has at most one boundary between its run of ones and run of zeros.
    logic [WIDTH-2:0] edge_bits;

    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_edges
            assign edge_bits[gi] = q_reg[gi] ^ q_reg[gi+1];
        end
    endgenerate

    // Legality: "x & (x-1) == 0" is true for zero or a single set bit.
    logic ring_legal;
    logic johnson_legal;
    logic state_legal;

    assign ring_legal    = (q_reg != '0) && ((q_reg & (q_reg - 1'b1)) == '0);
    assign johnson_legal = ((edge_bits & (edge_bits - 1'b1)) == '0);
    assign state_legal   = mode ? johnson_legal : ring_legal;

    // Shifted state: the bit fed in at the vacated end is the bit falling
    // out of the other end, inverted in Johnson mode.
    logic             feed_bit;
    logic [WIDTH-1:0] shifted;

    assign feed_bit = (dir ? q_reg[WIDTH-1] : q_reg[0]) ^ mode;
    assign shifted  = dir ? {q_reg[WIDTH-2:0], feed_bit}
                          : {feed_bit, q_reg[WIDTH-1:1]};

    // Next-state selection: load > enabled step > hold (reset in the register).
    always_comb begin
        q_next       = q_reg;
        wrap_next    = 1'b0;
        illegal_next = 1'b0;
        if (load) begin
            q_next = load_value;
        end else if (enable) begin
            if (!state_legal) begin
                // Correction takes the whole cycle; no shift happens.
                q_next       = home_state;
                illegal_next = 1'b1;
            end else begin
                q_next    = shifted;
                wrap_next = (shifted == home_state);
            end
        end
    end

    // Register state and status pulses; reset returns to the mode's home.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_reg       <= home_state;
            wrap_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            q_reg       <= q_next;
            wrap_reg    <= wrap_next;
            illegal_reg <= illegal_next;
        end
    end

    assign q       = q_reg;
    assign wrap    = wrap_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_shift_counter_n.sv
// Directed testbench for shift_counter_n (WIDTH=4, RESET_POS=3).
module tb_shift_counter_n;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'b0000;
    logic [3:0] q;
    logic       wrap;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    shift_counter_n #(.WIDTH(4), .RESET_POS(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .q          (q),
        .wrap       (wrap),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One edge, then compare {q, wrap, illegal}.
    task automatic step_check(input string tag, input logic [3:0] exp_q,
                              input logic exp_wrap, input logic exp_ill);
        logic [5:0] obs;
        logic [5:0] exp;
        tick();
        obs = {q, wrap, illegal};
        exp = {exp_q, exp_wrap, exp_ill};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: q/wrap/illegal got %b/%b/%b expected %b/%b/%b",
                   tag, obs[5:2], obs[1], obs[0], exp[5:2], exp[1], exp[0]);
        end
        $display("step %-14s q=%b wrap=%b illegal=%b", tag, q, wrap, illegal);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset into ring home, then ring toward bit 0.
        reset = 1'b1; mode = 1'b0;
        step_check("rst_ring", 4'b1000, 0, 0);
        reset = 1'b0; enable = 1'b1; dir = 1'b0;
        step_check("ring_d0_1", 4'b0100, 0, 0);
        step_check("ring_d0_2", 4'b0010, 0, 0);
        step_check("ring_d0_3", 4'b0001, 0, 0);
        step_check("ring_d0_4", 4'b1000, 1, 0);

        // Reset into Johnson home, then Johnson toward bit 0.
        reset = 1'b1; mode = 1'b1;
        step_check("rst_john", 4'b0000, 0, 0);
        reset = 1'b0;
        step_check("john_d0_1", 4'b1000, 0, 0);
        step_check("john_d0_2", 4'b1100, 0, 0);
        step_check("john_d0_3", 4'b1110, 0, 0);
        step_check("john_d0_4", 4'b1111, 0, 0);
        step_check("john_d0_5", 4'b0111, 0, 0);
        step_check("john_d0_6", 4'b0011, 0, 0);
        step_check("john_d0_7", 4'b0001, 0, 0);
        step_check("john_d0_8", 4'b0000, 1, 0);

        // Ring toward MSB from 1000.
        mode = 1'b0; load = 1'b1; load_value = 4'b1000;
        step_check("load_1000", 4'b1000, 0, 0);
        load = 1'b0; dir = 1'b1;
        step_check("ring_d1_1", 4'b0001, 0, 0);
        step_check("ring_d1_2", 4'b0010, 0, 0);
        step_check("ring_d1_3", 4'b0100, 0, 0);
        step_check("ring_d1_4", 4'b1000, 1, 0);

        // Johnson toward MSB from 0000.
        mode = 1'b1; load = 1'b1; load_value = 4'b0000;
        step_check("load_0000_j", 4'b0000, 0, 0);
        load = 1'b0;
        step_check("john_d1_1", 4'b0001, 0, 0);
        step_check("john_d1_2", 4'b0011, 0, 0);
        step_check("john_d1_3", 4'b0111, 0, 0);
        step_check("john_d1_4", 4'b1111, 0, 0);
        step_check("john_d1_5", 4'b1110, 0, 0);
        step_check("john_d1_6", 4'b1100, 0, 0);
        step_check("john_d1_7", 4'b1000, 0, 0);
        step_check("john_d1_8", 4'b0000, 1, 0);

        // Illegal ring load, corrected on the next enabled edge.
        mode = 1'b0; dir = 1'b0; load = 1'b1; load_value = 4'b1010;
        step_check("load_1010", 4'b1010, 0, 0);
        load = 1'b0;
        step_check("fix_ring", 4'b1000, 0, 1);
        step_check("after_fix", 4'b0100, 0, 0);

        // Illegal Johnson load, and all-zero in ring mode.
        mode = 1'b1; load = 1'b1; load_value = 4'b0110;
        step_check("load_0110", 4'b0110, 0, 0);
        load = 1'b0;
        step_check("fix_john", 4'b0000, 0, 1);
        mode = 1'b0; load = 1'b1; load_value = 4'b0000;
        step_check("load_0000_r", 4'b0000, 0, 0);
        load = 1'b0;
        step_check("fix_zero", 4'b1000, 0, 1);

        // Hold clears the status pulses and keeps q.
        enable = 1'b0;
        step_check("hold_1", 4'b1000, 0, 0);
        step_check("hold_2", 4'b1000, 0, 0);
        step_check("hold_3", 4'b1000, 0, 0);

        // Reset beats load and enable on the same edge.
        enable = 1'b1; load = 1'b1; load_value = 4'b0101; reset = 1'b1;
        step_check("rst_priority", 4'b1000, 0, 0);
        reset = 1'b0; load = 1'b0;
        step_check("pre_switch", 4'b0100, 0, 0);
        mode = 1'b1;
        step_check("switch_fix", 4'b0000, 0, 1);

        // Load beats enable; hot bit at index 0 is legal in Johnson.
        mode = 1'b0; load = 1'b1; load_value = 4'b0001;
        step_check("load_prio", 4'b0001, 0, 0);
        load = 1'b0; mode = 1'b1;
        step_check("switch_legal", 4'b0000, 1, 0);

        // Dir change mid-sequence acts on the same edge.
        mode = 1'b0; dir = 1'b0; load = 1'b1; load_value = 4'b0010;
        step_check("load_0010", 4'b0010, 0, 0);
        load = 1'b0;
        step_check("dir0_step", 4'b0001, 0, 0);
        dir = 1'b1;
        step_check("dir1_step", 4'b0010, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
